// File: rtl/wb_stage.sv
// wb_stage: registered write-back stage with load wait, sub-word load extraction,
// one-cycle register-file write port, retire pulse and retired-instruction counter.
module wb_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter bit HAS_CSR          = 1,
    parameter int RETIRE_CNT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       alu_result,
    input  logic [DATA_WIDTH-1:0]       pc_plus4,
    input  logic [DATA_WIDTH-1:0]       csr_rdata,
    input  logic [1:0]                  wb_sel,
    input  logic                        regwrite_in,
    input  logic                        kill_wb,
    input  logic [4:0]                  rd_in,
    input  logic [2:0]                  load_funct3,
    input  logic [1:0]                  load_addr_lo,
    input  logic                        load_rvalid,
    input  logic [DATA_WIDTH-1:0]       load_rdata,
    output logic                        rf_we,
    output logic [4:0]                  rf_waddr,
    output logic [DATA_WIDTH-1:0]       rf_wdata,
    output logic                        busy,
    output logic                        retire_pulse,
    output logic [RETIRE_CNT_WIDTH-1:0] instret
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    localparam logic [1:0] SEL_ALU = 2'd0, SEL_MEM = 2'd1, SEL_PC4 = 2'd2;
    state_t state, state_nx;
    logic [4:0] rd_q, rd_c;
    logic rw_q, rw_c;
    logic [2:0] f3_q, f3_c;
    logic [1:0] lo_q, lo_c, sel_c;
    logic accept, done, go_wait;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [DATA_WIDTH-1:0] load_v, data_c;
    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT_LOAD);
    // While waiting, the captured fields describe the pending load, not the live inputs
    always_comb begin
        accept   = in_valid && in_ready;
        rd_c     = busy ? rd_q : rd_in;
        rw_c     = busy ? rw_q : regwrite_in;
        f3_c     = busy ? f3_q : load_funct3;
        lo_c     = busy ? lo_q : load_addr_lo;
        sel_c    = busy ? SEL_MEM : wb_sel;
        done     = busy ? load_rvalid : accept && !kill_wb && (wb_sel != SEL_MEM || load_rvalid);
        go_wait  = accept && !kill_wb && wb_sel == SEL_MEM && !load_rvalid;
        state_nx = busy ? (load_rvalid ? IDLE : WAIT_LOAD) : (go_wait ? WAIT_LOAD : IDLE);
        byte_v   = load_rdata[{lo_c, 3'b000} +: 8];
        half_v   = load_rdata[{lo_c[1], 4'b0000} +: 16];
        load_v   = f3_c == 3'd0 ? {{(DATA_WIDTH-8){byte_v[7]}}, byte_v} :
                   f3_c == 3'd1 ? {{(DATA_WIDTH-16){half_v[15]}}, half_v} :
                   f3_c == 3'd4 ? {{(DATA_WIDTH-8){1'b0}}, byte_v} :
                   f3_c == 3'd5 ? {{(DATA_WIDTH-16){1'b0}}, half_v} : load_rdata;
        data_c   = sel_c == SEL_ALU ? alu_result :
                   sel_c == SEL_MEM ? load_v :
                   sel_c == SEL_PC4 ? pc_plus4 : (HAS_CSR ? csr_rdata : '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            f3_q         <= '0;
            lo_q         <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_pulse <= 1'b0;
            instret      <= '0;
        end else begin
            state        <= state_nx;
            rf_we        <= done && rw_c && rd_c != 5'd0;
            retire_pulse <= done;
            if (go_wait) begin
                rd_q <= rd_in;
                rw_q <= regwrite_in;
                f3_q <= load_funct3;
                lo_q <= load_addr_lo;
            end
            if (done) begin
                rf_waddr <= rd_c;
                rf_wdata <= data_c;
                instret  <= instret + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage, with a HAS_CSR=0 twin sharing all inputs.
module tb_wb_stage;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 0, regwrite_in = 0, kill_wb = 0, load_rvalid = 0;
    logic [1:0] wb_sel = 0, load_addr_lo = 0;
    logic [2:0] load_funct3 = 0;
    logic [4:0] rd_in = 0;
    logic [31:0] alu_result = 0, pc_plus4 = 0, csr_rdata = 0, load_rdata = 0;
    logic in_ready, busy, rf_we, retire_pulse;
    logic [4:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] instret;
    logic in_ready0, busy0, rf_we0, retire_pulse0;
    logic [4:0] rf_waddr0;
    logic [31:0] rf_wdata0;
    logic [63:0] instret0;

    typedef struct {logic we; logic [4:0] addr; logic [31:0] d1; logic [31:0] d0; logic [63:0] cnt;} exp_t;
    exp_t q[$];
    int total = 0, bad = 0;
    logic [63:0] exp_cnt = 0;

    always #5 clk = ~clk;

    wb_stage #(.DATA_WIDTH(32), .HAS_CSR(1), .RETIRE_CNT_WIDTH(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata), .wb_sel(wb_sel),
        .regwrite_in(regwrite_in), .kill_wb(kill_wb), .rd_in(rd_in), .load_funct3(load_funct3),
        .load_addr_lo(load_addr_lo), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy),
        .retire_pulse(retire_pulse), .instret(instret));

    wb_stage #(.DATA_WIDTH(32), .HAS_CSR(0), .RETIRE_CNT_WIDTH(64)) u_nocsr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata), .wb_sel(wb_sel),
        .regwrite_in(regwrite_in), .kill_wb(kill_wb), .rd_in(rd_in), .load_funct3(load_funct3),
        .load_addr_lo(load_addr_lo), .load_rvalid(load_rvalid), .load_rdata(load_rdata),
        .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0), .busy(busy0),
        .retire_pulse(retire_pulse0), .instret(instret0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic we, input logic [4:0] addr, input logic [31:0] d1, input logic [31:0] d0);
        exp_cnt++;
        q.push_back('{we, addr, d1, d0, exp_cnt});
    endtask

    // Present one instruction; d lands on the selected non-memory source, the others get filler
    task automatic drive(input logic [1:0] sel, input logic rw, input logic kill, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d,
                         input logic rv, input logic [31:0] rdata);
        in_valid = 1; wb_sel = sel; regwrite_in = rw; kill_wb = kill; rd_in = rd;
        load_funct3 = f3; load_addr_lo = lo; load_rvalid = rv; load_rdata = rdata;
        alu_result = sel == 2'd0 ? d : 32'h1111_1111;
        pc_plus4   = sel == 2'd2 ? d : 32'h2222_2222;
        csr_rdata  = sel == 2'd3 ? d : 32'h3333_3333;
    endtask

    task automatic idle();
        in_valid = 0; load_rvalid = 0; kill_wb = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " rf_we"}, 64'(rf_we), 64'd0);
        chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'd0);
        chk({tag, " rf_wdata"}, 64'(rf_wdata), 64'd0);
        chk({tag, " retire"}, 64'(retire_pulse), 64'd0);
        chk({tag, " instret"}, instret, 64'd0);
    endtask

    // Monitor: every retire pops one expectation; between retires the write port must hold
    logic [4:0] last_a = 0;
    logic [31:0] last_d = 0, last_d0 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = 0; last_d = 0; last_d0 = 0;
        end else if (retire_pulse || retire_pulse0) begin
            if (q.size() == 0) begin
                chk("unexpected retire", 64'(retire_pulse), 64'd0);
                last_a = rf_waddr; last_d = rf_wdata; last_d0 = rf_wdata0;
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("retire twin", 64'(retire_pulse0), 64'(retire_pulse));
                chk("rf_we", 64'(rf_we), 64'(e.we));
                chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                chk("rf_wdata", 64'(rf_wdata), 64'(e.d1));
                chk("instret", instret, e.cnt);
                chk("nocsr rf_we", 64'(rf_we0), 64'(e.we));
                chk("nocsr rf_wdata", 64'(rf_wdata0), 64'(e.d0));
                last_a = e.addr; last_d = e.d1; last_d0 = e.d0;
            end
        end else begin
            chk("idle rf_we", 64'(rf_we), 64'd0);
            chk("hold rf_waddr", 64'(rf_waddr), 64'(last_a));
            chk("hold rf_wdata", 64'(rf_wdata), 64'(last_d));
            chk("hold nocsr rf_wdata", 64'(rf_wdata0), 64'(last_d0));
        end
    end

    initial begin
        #1;
        chk_reset_outputs("reset");
        repeat (2) step();
        rst_n = 1;
        step();

        // back-to-back ALU then PC4
        drive(2'd0, 1, 0, 5'd10, 3'd2, 2'd0, 32'hA1A1_A1A1, 0, 0);
        push(1, 5'd10, 32'hA1A1_A1A1, 32'hA1A1_A1A1);
        step();
        chk("b2b first we", 64'(rf_we), 64'd1);
        chk("b2b first addr", 64'(rf_waddr), 64'd10);
        drive(2'd2, 1, 0, 5'd31, 3'd2, 2'd0, 32'hC3C3_C3C3, 0, 0);
        push(1, 5'd31, 32'hC3C3_C3C3, 32'hC3C3_C3C3);
        step();
        idle();
        chk("b2b second we", 64'(rf_we), 64'd1);
        chk("b2b second data", 64'(rf_wdata), 64'hC3C3_C3C3);
        chk("b2b instret", instret, 64'd2);
        step();

        // late LB; live load fields change while waiting to prove they were captured
        drive(2'd1, 1, 0, 5'd7, 3'd0, 2'd3, 0, 0, 0);
        step();
        idle();
        load_funct3 = 3'd2; load_addr_lo = 2'd0; rd_in = 5'd9;
        for (int i = 0; i < 3; i++) begin
            chk("late busy", 64'(busy), 64'd1);
            chk("late in_ready", 64'(in_ready), 64'd0);
            if (i == 2) begin
                load_rvalid = 1; load_rdata = 32'h80B2_B2B2;
                push(1, 5'd7, 32'hFFFF_FF80, 32'hFFFF_FF80);
            end
            step();
        end
        load_rvalid = 0;
        chk("late done busy", 64'(busy), 64'd0);
        chk("late done in_ready", 64'(in_ready), 64'd1);
        chk("late LB data", 64'(rf_wdata), 64'hFFFF_FF80);
        step();

        // same-cycle sub-word loads
        drive(2'd1, 1, 0, 5'd12, 3'd5, 2'd2, 0, 1, 32'h8001_B2B2);
        push(1, 5'd12, 32'h0000_8001, 32'h0000_8001);
        step();
        chk("LHU data", 64'(rf_wdata), 64'h0000_8001);
        drive(2'd1, 1, 0, 5'd13, 3'd1, 2'd2, 0, 1, 32'h8001_B2B2);
        push(1, 5'd13, 32'hFFFF_8001, 32'hFFFF_8001);
        step();
        chk("LH data", 64'(rf_wdata), 64'hFFFF_8001);
        drive(2'd1, 1, 0, 5'd14, 3'd1, 2'd1, 0, 1, 32'h8001_B2B2);
        push(1, 5'd14, 32'hFFFF_B2B2, 32'hFFFF_B2B2);
        step();
        drive(2'd1, 1, 0, 5'd15, 3'd4, 2'd1, 0, 1, 32'h8001_B2B2);
        push(1, 5'd15, 32'h0000_00B2, 32'h0000_00B2);
        step();
        drive(2'd1, 1, 0, 5'd16, 3'd7, 2'd1, 0, 1, 32'h8001_B2B2);
        push(1, 5'd16, 32'h8001_B2B2, 32'h8001_B2B2);
        step();
        idle();
        step();

        // kill, x0 and regwrite=0
        drive(2'd0, 1, 1, 5'd5, 3'd2, 2'd0, 32'hDEAD_BEEF, 0, 0);
        step();
        chk("kill rf_we", 64'(rf_we), 64'd0);
        chk("kill retire", 64'(retire_pulse), 64'd0);
        drive(2'd1, 1, 1, 5'd6, 3'd2, 2'd0, 0, 0, 0);
        step();
        chk("killed load busy", 64'(busy), 64'd0);
        drive(2'd0, 1, 0, 5'd0, 3'd2, 2'd0, 32'h1234_5678, 0, 0);
        push(0, 5'd0, 32'h1234_5678, 32'h1234_5678);
        step();
        chk("x0 rf_we", 64'(rf_we), 64'd0);
        chk("x0 retire", 64'(retire_pulse), 64'd1);
        drive(2'd2, 0, 0, 5'd9, 3'd2, 2'd0, 32'h0BAD_F00D, 0, 0);
        push(0, 5'd9, 32'h0BAD_F00D, 32'h0BAD_F00D);
        step();
        idle();
        step();

        // CSR source on both variants
        drive(2'd3, 1, 0, 5'd20, 3'd2, 2'd0, 32'hD4D4_D4D4, 0, 0);
        push(1, 5'd20, 32'hD4D4_D4D4, 32'h0000_0000);
        step();
        idle();
        step();

        // stray load_rvalid in IDLE must not retire
        load_rvalid = 1; load_rdata = 32'h5555_5555;
        step();
        load_rvalid = 0;
        chk("stray rvalid busy", 64'(busy), 64'd0);
        step();

        // reset during WAIT_LOAD drops the pending load
        drive(2'd1, 1, 0, 5'd8, 3'd2, 2'd0, 0, 0, 0);
        step();
        idle();
        step();
        chk("pre-reset busy", 64'(busy), 64'd1);
        rst_n = 0;
        #1;
        chk_reset_outputs("mid-wait reset");
        exp_cnt = 0;
        step();
        rst_n = 1;
        load_rvalid = 1; load_rdata = 32'h7777_7777;
        step();
        load_rvalid = 0;
        chk("post-reset retire", 64'(retire_pulse), 64'd0);
        chk("post-reset rf_we", 64'(rf_we), 64'd0);
        chk("post-reset instret", instret, 64'd0);
        repeat (2) step();
        chk("scoreboard drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
